// File: rtl/regfile_wb_writer.sv
// Register-file write-back merger: arbitrates ALU/LSU/MDU results onto the single
// regfile write port and tracks in-flight destinations in a pending-write scoreboard.
module regfile_wb_writer #(
  parameter int rnum_width = 5,
  parameter int data_width = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_alu_valid,
  input  logic [rnum_width-1:0] i_alu_rd,
  input  logic [data_width-1:0] i_alu_data,
  input  logic                  i_lsu_valid,
  output logic                  o_lsu_ready,
  input  logic [rnum_width-1:0] i_lsu_rd,
  input  logic [data_width-1:0] i_lsu_data,
  input  logic                  i_mdu_valid,
  output logic                  o_mdu_ready,
  input  logic [rnum_width-1:0] i_mdu_rd,
  input  logic [data_width-1:0] i_mdu_data,
  input  logic                  i_iss_valid,
  input  logic [rnum_width-1:0] i_iss_rd,
  input  logic [rnum_width-1:0] i_q1,
  input  logic [rnum_width-1:0] i_q2,
  output logic                  o_busy1,
  output logic                  o_busy2,
  output logic                  o_write,
  output logic [rnum_width-1:0] o_rd,
  output logic [data_width-1:0] o_data,
  output logic                  o_sb_err
);

  localparam int NREG = 1 << rnum_width;
  localparam logic [rnum_width-1:0] RZERO = {rnum_width{1'b0}};
  localparam logic [NREG-1:0] ONE_HOT0 = {{(NREG-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_ALU  = 2'd1,
    GNT_LSU  = 2'd2,
    GNT_MDU  = 2'd3
  } grant_t;

  grant_t                w_grant;
  logic                  w_accept;
  logic [rnum_width-1:0] w_rd;
  logic [data_width-1:0] w_data;
  logic                  w_iss_live;
  logic                  w_res_live;
  logic                  w_err;
  logic [NREG-1:0]       w_pend_set;
  logic [NREG-1:0]       w_pend_clr;
  logic [NREG-1:0]       w_pend_next;

  logic                  r_rr_mdu;   // 1: MDU wins the next LSU/MDU tie
  logic [NREG-1:0]       r_pending;
  logic                  r_write;
  logic [rnum_width-1:0] r_rd;
  logic [data_width-1:0] r_data;
  logic                  r_sb_err;

  // ALU has absolute priority; LSU/MDU ties alternate.
  always_comb begin
    w_grant = GNT_NONE;
    if (i_alu_valid) begin
      w_grant = GNT_ALU;
    end else if (i_lsu_valid && i_mdu_valid) begin
      w_grant = r_rr_mdu ? GNT_MDU : GNT_LSU;
    end else if (i_lsu_valid) begin
      w_grant = GNT_LSU;
    end else if (i_mdu_valid) begin
      w_grant = GNT_MDU;
    end else begin
      w_grant = GNT_NONE;
    end
  end

  // Select the granted payload.
  always_comb begin
    w_rd   = RZERO;
    w_data = {data_width{1'b0}};
    case (w_grant)
      GNT_ALU: begin w_rd = i_alu_rd; w_data = i_alu_data; end
      GNT_LSU: begin w_rd = i_lsu_rd; w_data = i_lsu_data; end
      GNT_MDU: begin w_rd = i_mdu_rd; w_data = i_mdu_data; end
      default: begin w_rd = RZERO;    w_data = {data_width{1'b0}}; end
    endcase
  end

  assign w_accept   = (w_grant != GNT_NONE);
  assign w_iss_live = i_iss_valid && (i_iss_rd != RZERO);
  assign w_res_live = w_accept && (w_rd != RZERO);
  assign w_err      = (w_iss_live && r_pending[i_iss_rd]) ||
                      (w_res_live && !r_pending[w_rd]);

  // Set is applied after clear so a same-cycle issue to the retiring register wins.
  assign w_pend_set  = w_iss_live ? (ONE_HOT0 << i_iss_rd) : {NREG{1'b0}};
  assign w_pend_clr  = w_res_live ? (ONE_HOT0 << w_rd)     : {NREG{1'b0}};
  assign w_pend_next = ((r_pending & ~w_pend_clr) | w_pend_set) & ~ONE_HOT0;

  assign o_lsu_ready = (w_grant == GNT_LSU);
  assign o_mdu_ready = (w_grant == GNT_MDU);
  assign o_busy1     = (i_q1 != RZERO) && r_pending[i_q1];
  assign o_busy2     = (i_q2 != RZERO) && r_pending[i_q2];

  // Output register, scoreboard, round-robin pointer and sticky error.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_write   <= 1'b0;
      r_rd      <= RZERO;
      r_data    <= {data_width{1'b0}};
      r_pending <= {NREG{1'b0}};
      r_rr_mdu  <= 1'b0;
      r_sb_err  <= 1'b0;
    end else begin
      r_pending <= w_pend_next;
      if (w_accept) begin
        r_rd    <= w_rd;
        r_data  <= w_data;
        r_write <= (w_rd != RZERO);
      end else begin
        r_write <= 1'b0;
      end
      if (w_grant == GNT_LSU) begin
        r_rr_mdu <= 1'b1;
      end else if (w_grant == GNT_MDU) begin
        r_rr_mdu <= 1'b0;
      end else begin
        r_rr_mdu <= r_rr_mdu;
      end
      if (w_err) begin
        r_sb_err <= 1'b1;
      end else begin
        r_sb_err <= r_sb_err;
      end
    end
  end

  assign o_write  = r_write;
  assign o_rd     = r_rd;
  assign o_data   = r_data;
  assign o_sb_err = r_sb_err;

endmodule

// File: tb/tb_regfile_wb_writer.sv
// Self-checking bench for regfile_wb_writer: directed scenarios plus a randomized
// phase, all compared against a behavioural scoreboard/regfile model.
module tb_regfile_wb_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, lsu_valid, mdu_valid, iss_valid;
  logic [4:0]  alu_rd, lsu_rd, mdu_rd, iss_rd, q1, q2;
  logic [31:0] alu_data, lsu_data, mdu_data;
  logic        lsu_ready, mdu_ready, busy1, busy2, wr, sb_err;
  logic [4:0]  rd;
  logic [31:0] data;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit  [31:0]  m_pend;
  logic [31:0] m_rf [32];
  logic [31:0] tb_rf [32];
  bit          m_err;
  bit          m_mdu_next;
  logic        m_write;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  int          last_g;

  regfile_wb_writer #(.rnum_width(5), .data_width(32)) dut (
    .i_clock(clk), .i_reset(reset),
    .i_alu_valid(alu_valid), .i_alu_rd(alu_rd), .i_alu_data(alu_data),
    .i_lsu_valid(lsu_valid), .o_lsu_ready(lsu_ready), .i_lsu_rd(lsu_rd), .i_lsu_data(lsu_data),
    .i_mdu_valid(mdu_valid), .o_mdu_ready(mdu_ready), .i_mdu_rd(mdu_rd), .i_mdu_data(mdu_data),
    .i_iss_valid(iss_valid), .i_iss_rd(iss_rd), .i_q1(q1), .i_q2(q2),
    .o_busy1(busy1), .o_busy2(busy2), .o_write(wr), .o_rd(rd), .o_data(data),
    .o_sb_err(sb_err)
  );

  always #5 clk = ~clk;

  // regfile as seen by the write port: commits on negedge
  always @(negedge clk) if (wr === 1'b1) tb_rf[rd] <= data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic cycle();
    int g;
    logic [4:0]  grd;
    logic [31:0] gd;
    #1;
    if (alu_valid)                   g = 1;
    else if (lsu_valid && mdu_valid) g = m_mdu_next ? 3 : 2;
    else if (lsu_valid)              g = 2;
    else if (mdu_valid)              g = 3;
    else                             g = 0;
    chk("lsu_ready", lsu_ready, (g == 2));
    chk("mdu_ready", mdu_ready, (g == 3));
    chk("busy1", busy1, (q1 != 5'd0) && m_pend[q1]);
    chk("busy2", busy2, (q2 != 5'd0) && m_pend[q2]);
    grd = (g == 1) ? alu_rd : (g == 2) ? lsu_rd : mdu_rd;
    gd  = (g == 1) ? alu_data : (g == 2) ? lsu_data : mdu_data;
    if (iss_valid && iss_rd != 5'd0 && m_pend[iss_rd]) m_err = 1'b1;
    if (g != 0 && grd != 5'd0 && !m_pend[grd]) m_err = 1'b1;
    if (g != 0 && grd != 5'd0) m_pend[grd] = 1'b0;
    if (iss_valid && iss_rd != 5'd0) m_pend[iss_rd] = 1'b1;
    if (g == 2) m_mdu_next = 1'b1;
    else if (g == 3) m_mdu_next = 1'b0;
    if (g != 0) begin
      m_rd = grd; m_data = gd; m_write = (grd != 5'd0);
      if (m_write) m_rf[grd] = gd;
    end else begin
      m_write = 1'b0;
    end
    last_g = g;
    @(posedge clk); #1;
    chk("write", wr, m_write);
    chk("rd", rd, m_rd);
    chk("data", data, m_data);
    chk("sb_err", sb_err, m_err);
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; lsu_valid = 1'b0; mdu_valid = 1'b0; iss_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    m_pend = '0; m_err = 1'b0; m_mdu_next = 1'b0;
    m_write = 1'b0; m_rd = 5'd0; m_data = 32'd0;
    chk("rst_write", wr, 1'b0);
    chk("rst_rd", rd, 5'd0);
    chk("rst_data", data, 32'd0);
    chk("rst_sb_err", sb_err, 1'b0);
    chk("rst_busy1", busy1, 1'b0);
    chk("rst_busy2", busy2, 1'b0);
  endtask

  task automatic issue(input logic [4:0] r);
    iss_valid = 1'b1; iss_rd = r;
    cycle();
    iss_valid = 1'b0;
  endtask

  task automatic readback(input int r);
    @(negedge clk); #1;
    chk("readback", tb_rf[r], m_rf[r]);
  endtask

  initial begin
    int order[3];
    int n, nl, nm;
    bit done;
    for (int i = 0; i < 32; i++) begin m_rf[i] = 32'd0; tb_rf[i] = 32'd0; end
    idle_inputs();
    alu_rd = 5'd0; lsu_rd = 5'd0; mdu_rd = 5'd0; iss_rd = 5'd0;
    alu_data = 32'd0; lsu_data = 32'd0; mdu_data = 32'd0;
    q1 = 5'd5; q2 = 5'd3;

    // 1: reset
    do_reset();

    // 2: ALU write to r5
    issue(5'd5);
    chk("busy_r5_set", busy1, 1'b1);
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    cycle();
    alu_valid = 1'b0;
    chk("alu_write", wr, 1'b1);
    chk("alu_data", data, 32'hDEADBEEF);
    chk("busy_r5_clr", busy1, 1'b0);
    readback(5);

    // 3: three-way contention
    q1 = 5'd7; q2 = 5'd9;
    issue(5'd6); issue(5'd7); issue(5'd9);
    alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h0000_0606;
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h0000_0707;
    mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_data = 32'h0000_0909;
    n = 0; nl = 0; nm = 0; done = 1'b0;
    for (int c = 0; c < 8 && !done; c++) begin
      cycle();
      if (n < 3) order[n] = last_g;
      n++;
      if (last_g == 1) alu_valid = 1'b0;
      if (last_g == 2) begin lsu_valid = 1'b0; nl++; end
      if (last_g == 3) begin mdu_valid = 1'b0; nm++; end
      done = !alu_valid && !lsu_valid && !mdu_valid;
    end
    chk("contention_done", done, 1'b1);
    chk("order0_alu", order[0], 1);
    chk("order1_lsu", order[1], 2);
    chk("order2_mdu", order[2], 3);
    chk("lsu_pulses", nl, 1);
    chk("mdu_pulses", nm, 1);
    // repeat tie: MDU was granted last, so LSU wins first, then MDU
    issue(5'd7); issue(5'd9);
    lsu_valid = 1'b1; lsu_data = 32'h1111_0707;
    mdu_valid = 1'b1; mdu_data = 32'h1111_0909;
    cycle();
    chk("rr_first_lsu", last_g, 2);
    lsu_valid = 1'b0;
    cycle();
    chk("rr_then_mdu", last_g, 3);
    mdu_valid = 1'b0;

    // 4: LSU backpressure under continuous ALU traffic
    issue(5'd15);
    for (int r = 10; r < 14; r++) issue(r[4:0]);
    lsu_valid = 1'b1; lsu_rd = 5'd15; lsu_data = 32'hCAFE_F00D;
    for (int r = 10; r < 14; r++) begin
      alu_valid = 1'b1; alu_rd = r[4:0]; alu_data = 32'hA000_0000 + r;
      cycle();
      chk("bp_lsu_held", lsu_ready, 1'b0);
    end
    alu_valid = 1'b0;
    cycle();
    chk("bp_lsu_accept", last_g, 2);
    lsu_valid = 1'b0;
    chk("bp_lsu_data", data, 32'hCAFE_F00D);

    // 5: result to r0
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h0000_1234;
    cycle();
    lsu_valid = 1'b0;
    chk("r0_accepted", last_g, 2);
    chk("r0_no_write", wr, 1'b0);
    chk("r0_no_err", sb_err, 1'b0);
    readback(0);

    // 6: protocol violations
    issue(5'd3);
    issue(5'd3);
    chk("double_issue_err", sb_err, 1'b1);
    do_reset();
    mdu_valid = 1'b1; mdu_rd = 5'd4; mdu_data = 32'h4444_4444;
    cycle();
    mdu_valid = 1'b0;
    chk("unpend_result_err", sb_err, 1'b1);
    chk("unpend_result_write", wr, 1'b1);

    // randomized traffic with producers honouring the handshake
    do_reset();
    for (int c = 0; c < 400; c++) begin
      alu_valid = ($urandom_range(3) == 0);
      alu_rd = 5'($urandom_range(7)); alu_data = $urandom;
      if (!lsu_valid && $urandom_range(2) == 0) begin
        lsu_valid = 1'b1; lsu_rd = 5'($urandom_range(7)); lsu_data = $urandom;
      end
      if (!mdu_valid && $urandom_range(2) == 0) begin
        mdu_valid = 1'b1; mdu_rd = 5'($urandom_range(7)); mdu_data = $urandom;
      end
      iss_valid = $urandom_range(1) == 1;
      iss_rd = 5'($urandom_range(7));
      q1 = 5'($urandom_range(7)); q2 = 5'($urandom_range(7));
      cycle();
      if (last_g == 2) lsu_valid = 1'b0;
      if (last_g == 3) mdu_valid = 1'b0;
      if (c % 50 == 49) begin
        readback(int'(m_rd));
        do_reset();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
